// File: rtl/image_burst_buffer.sv
// Ping-pong image buffer: packs incoming pixels into THROUGHPUT-wide words and
// replays each complete image as an unbroken burst of 2^LOG2_IMG_SIZE beats.
module image_burst_buffer #(
  parameter int NO_CH         = 2,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int THROUGHPUT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [NO_CH-1:0] in_data,
  input  logic             in_last,
  output logic             vld_out,
  output logic [NO_CH-1:0] data_out [THROUGHPUT-1:0],
  output logic             out_last,
  output logic             align_err
);

  localparam int WORD_W = THROUGHPUT * NO_CH;
  localparam int DEPTH  = 1 << LOG2_IMG_SIZE;
  localparam int LANE_W = (THROUGHPUT > 1) ? $clog2(THROUGHPUT) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [LANE_W-1:0]        lane_cnt;
  logic [LANE_W-1:0]        lane_idx;
  logic [LOG2_IMG_SIZE-1:0] wr_word_cnt;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [1:0]               full;
  logic [1:0]               full_nxt;
  logic [NO_CH-1:0]         lane_buf [THROUGHPUT-1:0];
  logic [WORD_W-1:0]        mem [0:2*DEPTH-1];
  logic [WORD_W-1:0]        wr_word;

  logic [0:0]               state;
  logic [LOG2_IMG_SIZE-1:0] rd_addr;
  logic                     rd_en;
  logic                     rd_final;

  logic                     vld_p1;
  logic                     last_p1;
  logic [WORD_W-1:0]        rd_word_p1;

  logic accept;
  logic lane_last;
  logic img_end;
  logic complete;
  logic early_last;
  logic mem_we;

  assign in_rdy     = !rst && !full[wr_bank];
  assign accept     = in_vld && in_rdy;
  assign lane_last  = (lane_cnt == LANE_W'(THROUGHPUT - 1));
  assign img_end    = lane_last && (wr_word_cnt == '1);
  assign complete   = accept && img_end;
  assign early_last = accept && in_last && !img_end;
  assign mem_we     = accept && lane_last && !early_last;
  // First pixel of a word lands in the highest lane (oldest = highest index).
  assign lane_idx   = LANE_W'(THROUGHPUT - 1) - lane_cnt;

  assign rd_en    = (state == BURST);
  assign rd_final = rd_en && (rd_addr == '1);

  always_comb begin
    wr_word = '0;
    for (int i = 0; i < THROUGHPUT; i++) begin
      wr_word[i*NO_CH +: NO_CH] = lane_buf[i];
    end
    wr_word[NO_CH-1:0] = in_data;
  end

  always_comb begin
    full_nxt = full;
    if (rd_final) full_nxt[rd_bank] = 1'b0;
    if (complete) full_nxt[wr_bank] = 1'b1;
  end

  // ---- write side: lane packing and image framing ----
  always_ff @(posedge clk) begin
    if (accept) lane_buf[lane_idx] <= in_data;
    if (mem_we) mem[{wr_bank, wr_word_cnt}] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt    <= '0;
      wr_word_cnt <= '0;
      wr_bank     <= 1'b0;
      align_err   <= 1'b0;
      full        <= '0;
    end else begin
      full <= full_nxt;
      if (early_last) begin
        // Short image: discard it and restart framing in the same bank.
        lane_cnt    <= '0;
        wr_word_cnt <= '0;
        align_err   <= 1'b1;
      end else if (accept) begin
        if (complete && !in_last) align_err <= 1'b1;
        if (lane_last) begin
          lane_cnt    <= '0;
          wr_word_cnt <= complete ? '0 : wr_word_cnt + 1'b1;
        end else begin
          lane_cnt <= lane_cnt + 1'b1;
        end
        if (complete) wr_bank <= ~wr_bank;
      end
    end
  end

  // ---- read side: burst FSM issuing one address per cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          rd_addr <= '0;
          if (full[rd_bank]) state <= BURST;
        end
        default: begin
          rd_addr <= rd_addr + 1'b1;
          if (rd_final) begin
            rd_bank <= ~rd_bank;
            // Chain straight into the other bank when it is already waiting.
            if (!full[~rd_bank]) state <= IDLE;
          end
        end
      endcase
    end
  end

  // ---- p1: registered memory read ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      rd_word_p1 <= '0;
    end else begin
      vld_p1  <= rd_en;
      last_p1 <= rd_final;
      if (rd_en) rd_word_p1 <= mem[{rd_bank, rd_addr}];
    end
  end

  assign vld_out  = vld_p1;
  assign out_last = last_p1;

  for (genvar g = 0; g < THROUGHPUT; g++) begin : g_unpack
    assign data_out[g] = rd_word_p1[g*NO_CH +: NO_CH];
  end

endmodule
